// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types for the data-memory port arbiter: arbiter state and the
// request bundle used for the CPU, debug and memory sides.
package Pipe_Buf_Reg_PKG;

    localparam int DM_ADDRESS_W = 9;
    localparam int DMEM_DATA_W  = 32;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_RESP = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic                    rd;
        logic                    wr;
        logic [DM_ADDRESS_W-1:0] addr;
        logic [DMEM_DATA_W-1:0]  wdata;
        logic [2:0]              funct3;
    } dmem_req_t;

endpackage

// File: rtl/dmem_port_arbiter_wait_counter.sv
// Saturating wait counter for blocked debug requests; clear wins over
// increment and the count parks at MAX_WAIT.
module arb_wait_counter #(
    parameter int MAX_WAIT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr_i,
    input  logic       inc_i,
    output logic [7:0] cnt_o,
    output logic       at_max_o
);

    localparam logic [7:0] MAX_C = 8'(MAX_WAIT);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 8'd0;
        end else if (inc_i && (cnt_q < MAX_C)) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o    = cnt_q;
    assign at_max_o = (cnt_q >= MAX_C);

endmodule

// File: rtl/dmem_port_arbiter.sv
// CPU/debug arbiter in front of the single-ported data memory. CPU has fixed
// priority; a starved debug request is forced through after MAX_WAIT cycles.
// Optional DMEM_ARB_STATS_EN adds saturating stall/grant statistics.
module dmem_port_arbiter
    import Pipe_Buf_Reg_PKG::*;
#(
    parameter int DM_ADDRESS = DM_ADDRESS_W,
    parameter int DATA_W     = DMEM_DATA_W,
    parameter int MAX_WAIT   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_rd,
    input  logic                  cpu_wr,
    input  logic [DM_ADDRESS-1:0] cpu_addr,
    input  logic [DATA_W-1:0]     cpu_wdata,
    input  logic [2:0]            cpu_funct3,
    output logic [DATA_W-1:0]     cpu_rdata,
    output logic                  cpu_stall,
    input  logic                  dbg_req_valid,
    output logic                  dbg_req_ready,
    input  logic                  dbg_we,
    input  logic [DM_ADDRESS-1:0] dbg_addr,
    input  logic [DATA_W-1:0]     dbg_wdata,
    input  logic [2:0]            dbg_funct3,
    output logic                  dbg_resp_valid,
    input  logic                  dbg_resp_ready,
    output logic [DATA_W-1:0]     dbg_rdata,
`ifdef DMEM_ARB_STATS_EN
    output logic [15:0]           stat_stall_cnt,
    output logic [15:0]           stat_dbg_cnt,
`endif
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [2:0]            mem_funct3,
    input  logic [DATA_W-1:0]     mem_rdata
);

    arb_state_e          state_q, state_d;
    logic                resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [7:0]          wait_cnt;
    logic                wait_at_max;
    logic                cpu_act;
    logic                dbg_grant;
    dmem_req_t           cpu_req, dbg_req, mem_req;

    assign cpu_act   = cpu_rd | cpu_wr;
    assign dbg_grant = ~reset & (state_q == ARB_IDLE) & dbg_req_valid &
                       (~cpu_act | wait_at_max);

    assign dbg_req_ready  = dbg_grant;
    assign cpu_stall      = dbg_grant & cpu_act;
    assign cpu_rdata      = mem_rdata;
    assign dbg_resp_valid = resp_valid_q;
    assign dbg_rdata      = rdata_q;

    assign cpu_req = '{rd: cpu_rd, wr: cpu_wr, addr: cpu_addr,
                       wdata: cpu_wdata, funct3: cpu_funct3};
    assign dbg_req = '{rd: ~dbg_we, wr: dbg_we, addr: dbg_addr,
                       wdata: dbg_wdata, funct3: dbg_funct3};
    assign mem_req = dbg_grant ? dbg_req : cpu_req;

    // Reset must never let a stale request strobe the memory.
    assign mem_rd     = mem_req.rd & ~reset;
    assign mem_wr     = mem_req.wr & ~reset;
    assign mem_addr   = mem_req.addr;
    assign mem_wdata  = mem_req.wdata;
    assign mem_funct3 = mem_req.funct3;

    arb_wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (dbg_grant | ~dbg_req_valid),
        .inc_i    ((state_q == ARB_IDLE) & dbg_req_valid & cpu_act & ~dbg_grant),
        .cnt_o    (wait_cnt),
        .at_max_o (wait_at_max)
    );

    // Next-state and response capture for the debug handshake.
    always_comb begin
        state_d      = state_q;
        resp_valid_d = resp_valid_q;
        rdata_d      = rdata_q;
        case (state_q)
            ARB_IDLE: begin
                if (dbg_grant) begin
                    state_d      = ARB_RESP;
                    resp_valid_d = 1'b1;
                    rdata_d      = dbg_we ? {DATA_W{1'b0}} : mem_rdata;
                end else begin
                    state_d      = ARB_IDLE;
                end
            end
            ARB_RESP: begin
                if (resp_valid_q && dbg_resp_ready) begin
                    state_d      = ARB_IDLE;
                    resp_valid_d = 1'b0;
                end else begin
                    state_d      = ARB_RESP;
                end
            end
            default: begin
                state_d      = ARB_IDLE;
                resp_valid_d = 1'b0;
            end
        endcase
    end

    // State and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ARB_IDLE;
            resp_valid_q <= 1'b0;
            rdata_q      <= {DATA_W{1'b0}};
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
        end
    end

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] dbg_cnt_q;

    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 16'd0;
            dbg_cnt_q   <= 16'd0;
        end else begin
            if (cpu_stall && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if (dbg_grant && (dbg_cnt_q != 16'hFFFF)) begin
                dbg_cnt_q <= dbg_cnt_q + 16'd1;
            end
        end
    end

    assign stat_stall_cnt = stall_cnt_q;
    assign stat_dbg_cnt   = dbg_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural data memory and a
// queue of expected debug responses.
module tb_dmem_port_arbiter;

    localparam int AW = 9;
    localparam int DW = 32;
    localparam int MW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_rd, cpu_wr;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [2:0]    cpu_funct3;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;
    logic          dbg_req_valid, dbg_req_ready, dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic [2:0]    dbg_funct3;
    logic          dbg_resp_valid, dbg_resp_ready;
    logic [DW-1:0] dbg_rdata;
    logic          mem_rd, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [2:0]    mem_funct3;
    logic [DW-1:0] mem_rdata;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0]   stat_stall_cnt, stat_dbg_cnt;
`endif

    logic [DW-1:0] tbmem [0:511];
    logic [DW-1:0] exp_q [$];
    int            n_checks = 0;
    int            n_errors = 0;

    always #5 clk = ~clk;

    assign mem_rdata = tbmem[mem_addr];
    always @(posedge clk) begin
        if (mem_wr) tbmem[mem_addr] <= mem_wdata;
    end

    dmem_port_arbiter #(.DM_ADDRESS(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_funct3(cpu_funct3),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready),
        .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_funct3(dbg_funct3), .dbg_resp_valid(dbg_resp_valid),
        .dbg_resp_ready(dbg_resp_ready), .dbg_rdata(dbg_rdata),
`ifdef DMEM_ARB_STATS_EN
        .stat_stall_cnt(stat_stall_cnt), .stat_dbg_cnt(stat_dbg_cnt),
`endif
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_funct3(mem_funct3), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_resp(input string tag);
        chk({tag, "_valid"}, 32'(dbg_resp_valid), 32'd1);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end else begin
            chk({tag, "_data"}, dbg_rdata, exp_q.pop_front());
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Debug read of daddr under continuous CPU reads of 0x40: forced grant on cycle MW+1.
    task automatic forced_read(input logic [AW-1:0] daddr, input logic [31:0] exp_data, input string tag);
        cpu_rd = 1'b1; cpu_addr = 9'h040;
        dbg_req_valid = 1'b1; dbg_we = 1'b0; dbg_addr = daddr;
        for (int c = 1; c <= MW + 1; c++) begin
            #1;
            chk({tag, "_ready"}, 32'(dbg_req_ready), 32'(c == MW + 1));
            chk({tag, "_stall"}, 32'(cpu_stall), 32'(c == MW + 1));
            if (c == MW + 1) exp_q.push_back(exp_data);
            tick();
        end
        dbg_req_valid = 1'b0; dbg_resp_ready = 1'b1;
        #1;
        chk({tag, "_nostall"}, 32'(cpu_stall), 32'd0);
        chk({tag, "_cpu_served"}, cpu_rdata, 32'hDEADBEEF);
        pop_resp(tag);
        tick();
        cpu_rd = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_funct3 = 3'b010;
        dbg_req_valid = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0; dbg_funct3 = 3'b010;
        dbg_resp_ready = 1'b1;
        tick(); tick();
        chk("rst_resp_valid", 32'(dbg_resp_valid), 32'd0);
        chk("rst_rdata", dbg_rdata, 32'd0);
        chk("rst_ready", 32'(dbg_req_ready), 32'd0);
        reset = 1'b0;

        // Idle CPU: debug write then read of 0x40.
        dbg_req_valid = 1'b1; dbg_we = 1'b1; dbg_addr = 9'h040; dbg_wdata = 32'hDEADBEEF;
        #1;
        chk("wr_ready", 32'(dbg_req_ready), 32'd1);
        chk("wr_stall", 32'(cpu_stall), 32'd0);
        chk("wr_mem_wr", 32'(mem_wr), 32'd1);
        chk("wr_mem_addr", 32'(mem_addr), 32'h040);
        chk("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
        exp_q.push_back(32'd0);
        tick();
        dbg_req_valid = 1'b0;
        #1;
        pop_resp("wr_resp");
        chk("resp_state_ready", 32'(dbg_req_ready), 32'd0);
        tick();
        dbg_req_valid = 1'b1; dbg_we = 1'b0;
        #1;
        chk("rd_ready", 32'(dbg_req_ready), 32'd1);
        chk("rd_stall", 32'(cpu_stall), 32'd0);
        chk("rd_mem_rd", 32'(mem_rd), 32'd1);
        exp_q.push_back(32'hDEADBEEF);
        tick();
        dbg_req_valid = 1'b0;
        #1;
        pop_resp("rd_resp");
        tick();

        // Continuous CPU reads with a pending debug read.
        forced_read(9'h040, 32'hDEADBEEF, "forced");

        // CPU store and debug read of 0x10 in the same cycle.
        cpu_wr = 1'b1; cpu_addr = 9'h010; cpu_wdata = 32'h12345678;
        dbg_req_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 9'h010;
        for (int c = 1; c <= MW + 1; c++) begin
            #1;
            chk("st_ready", 32'(dbg_req_ready), 32'(c == MW + 1));
            chk("st_mem_wr", 32'(mem_wr), 32'(c != MW + 1));
            if (c == MW + 1) exp_q.push_back(32'h12345678);
            tick();
        end
        cpu_wr = 1'b0; dbg_req_valid = 1'b0;
        #1;
        pop_resp("st_resp");
        tick();

        // Response back-pressure for five cycles.
        dbg_resp_ready = 1'b0; dbg_req_valid = 1'b1; dbg_addr = 9'h010;
        #1;
        chk("bp_ready", 32'(dbg_req_ready), 32'd1);
        exp_q.push_back(32'h12345678);
        tick();
        dbg_addr = 9'h040; cpu_rd = 1'b1; cpu_addr = 9'h040;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_valid", 32'(dbg_resp_valid), 32'd1);
            chk("bp_rdata", dbg_rdata, 32'h12345678);
            chk("bp_noready", 32'(dbg_req_ready), 32'd0);
            chk("bp_nostall", 32'(cpu_stall), 32'd0);
            chk("bp_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
            tick();
        end
        dbg_resp_ready = 1'b1;
        #1;
        pop_resp("bp_resp");
        tick();
        cpu_rd = 1'b0;
        #1;
        chk("bp_next_ready", 32'(dbg_req_ready), 32'd1);
        exp_q.push_back(32'hDEADBEEF);
        tick();
        dbg_req_valid = 1'b0;
        #1;
        pop_resp("bp_next_resp");
        tick();

        // Reset while a response is pending.
        dbg_resp_ready = 1'b0; dbg_req_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 9'h010;
        #1;
        chk("rr_ready", 32'(dbg_req_ready), 32'd1);
        exp_q.push_back(32'h12345678);
        tick();
        dbg_req_valid = 1'b0;
        #1;
        pop_resp("rr_resp");
        reset = 1'b1; cpu_wr = 1'b1; cpu_addr = 9'h040; cpu_wdata = 32'h0BADF00D;
        #1;
        chk("rr_mem_wr", 32'(mem_wr), 32'd0);
        chk("rr_mem_rd", 32'(mem_rd), 32'd0);
        tick();
        chk("rr_valid_drop", 32'(dbg_resp_valid), 32'd0);
        chk("rr_rdata_clr", dbg_rdata, 32'd0);
        chk("rr_wait_cnt", 32'(dut.wait_cnt), 32'd0);
        reset = 1'b0; cpu_wr = 1'b0; cpu_rd = 1'b1;
        #1;
        chk("rr_mem_kept", cpu_rdata, 32'hDEADBEEF);
        tick();
        cpu_rd = 1'b0; dbg_resp_ready = 1'b1;

`ifdef DMEM_ARB_STATS_EN
        chk("st_stall_rst", 32'(stat_stall_cnt), 32'd0);
        chk("st_dbg_rst", 32'(stat_dbg_cnt), 32'd0);
        for (int k = 0; k < 3; k++) forced_read(9'h010, 32'h12345678, "stat_forced");
        for (int k = 0; k < 2; k++) begin
            dbg_req_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 9'h040;
            #1;
            chk("stat_free_ready", 32'(dbg_req_ready), 32'd1);
            exp_q.push_back(32'hDEADBEEF);
            tick();
            dbg_req_valid = 1'b0;
            #1;
            pop_resp("stat_free");
            tick();
        end
        chk("stat_stall_cnt", 32'(stat_stall_cnt), 32'd3);
        chk("stat_dbg_cnt", 32'(stat_dbg_cnt), 32'd5);
`endif

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
